muldiv_ctrl: RTL and testbench

- Iterative multiply/divide sequencer that owns the HI/LO register pair for the pipelined MIPS core.
- Sits beside the EX stage and runs MULT, MULTU, DIV and DIVU over multiple cycles using one WIDTH-bit add/subtract path per iteration.
- Executes MTHI and MTLO directly.
- Asserts busy so the hazard logic stalls any MFHI/MFLO, or any new muldiv op, until results are final.

---
 rtl/muldiv_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO pair.
// Also executes MTHI/MTLO, and raises busy so hazard logic can stall MFHI/MFLO.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]    cnt_q, cnt_d;
    // acc: product high half while multiplying, partial remainder while dividing
    logic [WIDTH-1:0] acc_q, acc_d;
    // low: multiplier/product low half, or dividend/quotient
    logic [WIDTH-1:0] low_q, low_d;
    // opnd: multiplicand or divisor magnitude
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             div_q, div_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] rsraw_q, rsraw_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    // Operand conditioning for the signed forms
    logic             signed_op;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;

    // Shared add/subtract path, two guard bits for carry and borrow
    logic [WIDTH+1:0] add_a;
    logic [WIDTH+1:0] add_b;
    logic [WIDTH+1:0] sum;

    // Sign-corrected results used in FIX
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Magnitudes of the incoming operands; 0x80..0 maps to unsigned 2^(W-1)
    always_comb begin
        signed_op = ~op[0];
        rs_neg    = signed_op & rs_val[WIDTH-1];
        rt_neg    = signed_op & rt_val[WIDTH-1];
        rs_mag    = rs_neg ? (~rs_val + 1'b1) : rs_val;
        rt_mag    = rt_neg ? (~rt_val + 1'b1) : rt_val;
    end

    // One adder: acc+opnd for multiply, (acc:next bit)-opnd for divide
    always_comb begin
        add_a = div_q ? {1'b0, acc_q, low_q[WIDTH-1]}
                      : {2'b00, acc_q};
        add_b = div_q ? ~{2'b00, opnd_q} : {2'b00, opnd_q};
        sum   = add_a + add_b + {{(WIDTH+1){1'b0}}, div_q};
    end

    // Final sign fix-ups applied on the FIX edge
    always_comb begin
        prod     = {acc_q, low_q};
        prod_fix = neg_q ? (~prod + 1'b1) : prod;
        quo_fix  = neg_q ? (~low_q + 1'b1) : low_q;
        rem_fix  = rneg_q ? (~acc_q + 1'b1) : acc_q;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        low_d   = low_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        rsraw_d = rsraw_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        acc_d   = '0;
                        div_d   = op[1];
                        neg_d   = rs_neg ^ rt_neg;
                        rneg_d  = rs_neg;
                        dz_d    = op[1] & (rt_val == '0);
                        rsraw_d = rs_val;
                        low_d   = op[1] ? rs_mag : rt_mag;
                        opnd_d  = op[1] ? rt_mag : rs_mag;
                    end else if (op == 3'b100) begin
                        hi_d = rs_val;
                    end else if (op == 3'b101) begin
                        lo_d = rs_val;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (div_q) begin
                    if (!sum[WIDTH+1]) begin
                        acc_d = sum[WIDTH-1:0];
                        low_d = {low_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = add_a[WIDTH-1:0];
                        low_d = {low_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (low_q[0]) begin
                        acc_d = sum[WIDTH:1];
                        low_d = {sum[0], low_q[WIDTH-1:1]};
                    end else begin
                        acc_d = {1'b0, acc_q[WIDTH-1:1]};
                        low_d = {acc_q[0], low_q[WIDTH-1:1]};
                    end
                end
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                cnt_d   = '0;
                if (dz_q) begin
                    hi_d = rsraw_q;
                    lo_d = '1;
                end else if (div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and architectural registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            low_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            rsraw_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            low_q   <= low_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            rsraw_q <= rsraw_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: vector table, corner sequences and random ops
// checked against an arithmetic reference model.
module tb_muldiv_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total;
    int bad;

    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        string       nm;
    } vec_t;

    vec_t vecs[10];

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Reference: plain 64-bit arithmetic, C-style truncating division
    function automatic void model(input logic [2:0] o,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] h,
                                  output logic [31:0] l);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h  = 32'h0;
        l  = 32'h0;
        case (o)
            3'b000: begin
                p = 64'(sa * sb);
                h = p[63:32];
                l = p[31:0];
            end
            3'b001: begin
                p = {32'h0, a} * {32'h0, b};
                h = p[63:32];
                l = p[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else if (o == 3'b010) begin
                    q = sa / sb;
                    r = sa % sb;
                    h = r[31:0];
                    l = q[31:0];
                end else begin
                    h = a % b;
                    l = a / b;
                end
            end
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(negedge clk);
        start  = 1'b0;
        op     = 3'b110;
    endtask

    // inj=1: DIVU request on busy cycle 10 and MTHI on busy cycle 20
    task automatic run_iter(input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh,
                            input logic [31:0] el, input string nm,
                            input int inj);
        int n;
        bit hold_ok;
        issue(o, a, b);
        n = 0;
        hold_ok = 1'b1;
        while (busy === 1'b1 && n < 60) begin
            n++;
            start = 1'b0;
            if (hi !== exp_hi || lo !== exp_lo || done !== 1'b0)
                hold_ok = 1'b0;
            if (inj == 1 && n == 10) begin
                start  = 1'b1;
                op     = 3'b011;
                rs_val = 32'd9;
                rt_val = 32'd3;
            end else if (inj == 1 && n == 20) begin
                start  = 1'b1;
                op     = 3'b100;
                rs_val = 32'hDEAD_BEEF;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, "_busy_len"}, 32'(n), 32'd33);
        chk({nm, "_hold"}, 32'(hold_ok), 32'd1);
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        exp_hi = eh;
        exp_lo = el;
        @(negedge clk);
        chk({nm, "_done_clr"}, 32'(done), 32'd0);
    endtask

    task automatic run_mt(input logic [2:0] o, input logic [31:0] a,
                          input string nm);
        issue(o, a, 32'h0);
        if (o == 3'b100) exp_hi = a;
        if (o == 3'b101) exp_lo = a;
        chk({nm, "_hi"}, hi, exp_hi);
        chk({nm, "_lo"}, lo, exp_lo);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic reset_mid_op();
        int n;
        issue(3'b000, 32'hFFFF_FFFD, 32'd5);
        n = 1;
        while (busy === 1'b1 && n < 15) begin
            n++;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_hi", hi, 32'h0);
        chk("rst_mid_lo", lo, 32'h0);
        exp_hi = 32'h0;
        exp_lo = 32'h0;
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] mh;
        logic [31:0] ml;

        total  = 0;
        bad    = 0;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'b110;
        rs_val = 32'h0;
        rt_val = 32'h0;

        vecs[0] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
        vecs[1] = '{3'b000, 32'hFFFF_FFFD, 32'd5,
                    32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5"};
        vecs[2] = '{3'b010, 32'hFFFF_FFF9, 32'd2,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2"};
        vecs[3] = '{3'b011, 32'd100, 32'd7,
                    32'h0000_0002, 32'h0000_000E, "divu_100_7"};
        vecs[4] = '{3'b011, 32'd5, 32'd0,
                    32'h0000_0005, 32'hFFFF_FFFF, "divu_by0"};
        vecs[5] = '{3'b000, 32'h8000_0000, 32'h8000_0000,
                    32'h4000_0000, 32'h0000_0000, "mult_minmin"};
        vecs[6] = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF,
                    32'h0000_0000, 32'h8000_0000, "div_min_m1"};
        vecs[7] = '{3'b010, 32'hFFFF_FFF9, 32'd0,
                    32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0"};
        vecs[8] = '{3'b000, 32'd7, 32'hFFFF_FFFE,
                    32'hFFFF_FFFF, 32'hFFFF_FFF2, "mult_7xneg2"};
        vecs[9] = '{3'b010, 32'd7, 32'hFFFF_FFFE,
                    32'h0000_0001, 32'hFFFF_FFFD, "div_7_neg2"};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);

        run_mt(3'b100, 32'h1234_5678, "mthi");
        run_mt(3'b101, 32'hCAFE_BABE, "mtlo");
        run_mt(3'b110, 32'h5555_AAAA, "nop6");
        run_mt(3'b111, 32'hAAAA_5555, "nop7");

        for (int i = 0; i < 10; i++) begin
            run_iter(vecs[i].op, vecs[i].rs, vecs[i].rt,
                     vecs[i].hi, vecs[i].lo, vecs[i].nm, 0);
        end

        run_iter(3'b001, 32'd3, 32'd4, 32'h0, 32'd12, "interfere", 1);

        reset_mid_op();
        run_iter(3'b001, 32'd2, 32'd3, 32'h0, 32'd6, "after_rst", 0);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'hFFFF_FFFF;
                2:       ra = 32'h0;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0:       rb = 32'h8000_0000;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'h0;
                3:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            model(ro, ra, rb, mh, ml);
            run_iter(ro, ra, rb, mh, ml, $sformatf("rnd%0d", i), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
